fetch_unit: RTL

Instruction fetch front end for the single-issue CPU. Holds the program counter and runs a one-outstanding request/response handshake with instruction memory. Presents each fetched 32-bit instruction and its PC to decode/control with a valid/ready handshake. On consume, it takes the control block's `pc_src` to pick the next PC: sequential, jump, or taken branch.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/next_pc_calc.sv | 50 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Purpose: Shared definitions for the single-issue CPU front end: next-PC
//          select codes, instruction field bounds and the fetch FSM state
//          encoding.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Next-PC select codes driven by the control block on consume.
  // Code 2'b11 is not named; it falls through to sequential.
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

  // Instruction field bounds.
  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int IMM16_MSB   = 15;
  localparam int IMM16_LSB   = 0;
  localparam int JTARGET_MSB = 25;
  localparam int JTARGET_LSB = 0;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_t;

  // Sign-extend a 16-bit immediate to 32 bits.
  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module : next_pc_calc
// Purpose: Combinational next-PC computation from a held instruction and its
//          address. Shared so decode/branch units can reuse the arithmetic.
// Ports  : instr_pc [31:0] in  - address of instr
//          instr    [31:0] in  - instruction word
//          pc_src   [1:0]  in  - 00 seq, 01 jump, 10 branch, 11 seq
//          next_pc  [31:0] out - selected next PC (mod 2^32)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [31:0] instr,
  input  logic [1:0]  pc_src,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;
  logic [31:0] imm_ext;

  // The opcode bits do not take part in target arithmetic.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, instr[OPCODE_MSB:OPCODE_LSB]};

  assign seq_pc    = instr_pc + 32'd4;
  // Jump keeps the top nibble of the sequential PC (256 MB region).
  assign jump_pc   = {seq_pc[31:28], instr[JTARGET_MSB:JTARGET_LSB], 2'b00};
  assign imm_ext   = sext_imm16(instr[IMM16_MSB:IMM16_LSB]);
  // Word offset: shifting left by 2 drops the top two sign bits, which is
  // harmless because the sum is taken mod 2^32.
  assign branch_pc = seq_pc + {imm_ext[29:0], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (pc_src)
      PCSRC_JUMP:   next_pc = jump_pc;
      PCSRC_BRANCH: next_pc = branch_pc;
      default:      next_pc = seq_pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Purpose: Instruction fetch front end. Holds the PC, runs a one-outstanding
//          request/response handshake with instruction memory, and presents
//          each fetched instruction with its PC to decode via valid/ready.
// Ports  : clk, rst_n (sync, active-low)
//          fetch_en                      - allow new imem requests
//          imem_req_valid/ready, imem_addr - request channel
//          imem_rsp_valid, imem_rsp_data   - response channel
//          instr_valid/ready, instr, instr_pc - decode handshake
//          pc_src                         - next-PC select on consume
//          fetch_count                    - delivered instruction count
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic [1:0]  pc_src,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [31:0] pc;
  logic [31:0] next_pc;
  // fetch_en is registered so that imem_req_valid depends only on flops;
  // a change on fetch_en is therefore seen on the request one cycle later.
  logic        fetch_en_q;
  logic        do_capture;
  logic        do_consume;

  next_pc_calc u_next_pc_calc (
    .instr_pc (instr_pc),
    .instr    (instr),
    .pc_src   (pc_src),
    .next_pc  (next_pc)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output decode. Outputs use only registered state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    do_capture     = 1'b0;
    do_consume     = 1'b0;
    case (state)
      FS_IDLE: begin
        state_nxt = FS_REQ;
      end
      FS_REQ: begin
        imem_req_valid = fetch_en_q;
        if (fetch_en_q && imem_req_ready) begin
          state_nxt = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          do_capture = 1'b1;
          state_nxt  = FS_HOLD;
        end
      end
      FS_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          do_consume = 1'b1;
          state_nxt  = FS_REQ;
        end
      end
      default: begin
        state_nxt = FS_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_en_q  <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      fetch_en_q <= fetch_en;
      if (do_capture) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (do_consume) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // PC only changes on consume, so the address is stable across a stalled
  // or withdrawn request.
  assign imem_addr = pc;

endmodule

`default_nettype wire
